// File: rtl/obstacle_field.sv
// Scrolls N_OBS obstacles right-to-left on each frame tick, respawning them at random heights,
// detects plane collisions and runs the IDLE/RUN/OVER game state machine.
module obstacle_field #(
  parameter int N_OBS     = 4,
  parameter int COORD_W   = 10,
  parameter int X_SPAWN   = 600,
  parameter int X_LEFT    = 120,
  parameter int Y_BASE    = 100,
  parameter int YOFF_W    = 6,
  parameter int STEP_INIT = 8,
  parameter int STEP_INC  = 2,
  parameter int STEP_MAX  = 16,
  parameter int LEVEL_PTS = 8,
  parameter int SCORE_W   = 8,
  parameter int PLANE_X   = 160,
  parameter int PLANE_W   = 32,
  parameter int HIT_H     = 24
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       tick_i,
  input  logic                       start_i,
  input  logic [COORD_W-1:0]         plane_y_i,
  output logic [N_OBS*COORD_W-1:0]   obs_x_o,
  output logic [N_OBS*COORD_W-1:0]   obs_y_o,
  output logic [SCORE_W-1:0]         score_o,
  output logic [4:0]                 step_o,
  output logic                       game_over_o,
  output logic                       running_o,
  output logic [1:0]                 state_o
);

  localparam int CW1   = COORD_W + 1;
  localparam int SW1   = SCORE_W + 1;
  localparam int CNT_W = $clog2(N_OBS + 1);
  localparam int LVL_W = $clog2(LEVEL_PTS + N_OBS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [CW1-1:0]     XL_E     = CW1'(X_LEFT);
  localparam logic [CW1-1:0]     YB_E     = CW1'(Y_BASE);
  localparam logic [CW1-1:0]     PX_LO    = CW1'(PLANE_X);
  localparam logic [CW1-1:0]     PX_HI    = CW1'(PLANE_X + PLANE_W);
  localparam logic [CW1-1:0]     HIT_E    = CW1'(HIT_H);
  localparam logic [COORD_W-1:0] XS_C     = COORD_W'(X_SPAWN);
  localparam logic [COORD_W-1:0] YB_C     = COORD_W'(Y_BASE);
  localparam logic [4:0]         STEP_RST = 5'(STEP_INIT);
  localparam logic [5:0]         STEP_ADD = 6'(STEP_INC);
  localparam logic [5:0]         STEP_CAP = 6'(STEP_MAX);
  localparam logic [LVL_W-1:0]   LVL_PTS  = LVL_W'(LEVEL_PTS);

  function automatic logic [COORD_W-1:0] x_init(input int i);
    x_init = COORD_W'(X_LEFT + ((i + 1) * (X_SPAWN - X_LEFT)) / N_OBS);
  endfunction

  function automatic logic [7:0] lfsr_init(input int i);
    lfsr_init = {4'(i + 1), 4'hB};
  endfunction

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q [N_OBS];
  logic [COORD_W-1:0] x_d [N_OBS];
  logic [COORD_W-1:0] y_q [N_OBS];
  logic [COORD_W-1:0] y_d [N_OBS];
  logic [7:0]         lfsr_q [N_OBS];
  logic [7:0]         lfsr_d [N_OBS];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [4:0]         step_q, step_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;

  logic [N_OBS-1:0]   hit_w, resp_w;
  logic [COORD_W-1:0] x_mv    [N_OBS];
  logic [COORD_W-1:0] y_spawn [N_OBS];
  logic [7:0]         lfsr_nx [N_OBS];

  genvar g;
  for (g = 0; g < N_OBS; g++) begin : g_ch
    logic [CW1-1:0] xe, ye, pe, dy;
    assign xe = {1'b0, x_q[g]};
    assign ye = {1'b0, y_q[g]};
    assign pe = {1'b0, plane_y_i};
    // Subtract the smaller from the larger so the distance never underflows.
    assign dy = (ye >= pe) ? (ye - pe) : (pe - ye);
    assign hit_w[g]   = (xe >= PX_LO) && (xe < PX_HI) && (dy < HIT_E);
    assign resp_w[g]  = xe < (XL_E + CW1'(step_q));
    assign x_mv[g]    = COORD_W'(xe - CW1'(step_q));
    assign y_spawn[g] = COORD_W'(YB_E + CW1'(lfsr_q[g][YOFF_W-1:0]));
    // Fibonacci taps 8,6,5,4 feeding the LSB.
    assign lfsr_nx[g] = {lfsr_q[g][6:0], lfsr_q[g][7] ^ lfsr_q[g][5] ^ lfsr_q[g][4] ^ lfsr_q[g][3]};
    assign obs_x_o[g*COORD_W +: COORD_W] = x_q[g];
    assign obs_y_o[g*COORD_W +: COORD_W] = y_q[g];
  end

  logic [CNT_W-1:0]   cnt;
  logic [SW1-1:0]     score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [LVL_W-1:0]   lvl_sum;
  logic [5:0]         step_sum;
  logic [4:0]         step_up;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_OBS; i++) cnt = cnt + CNT_W'(resp_w[i]);
  end

  assign score_sum = {1'b0, score_q} + SW1'(cnt);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign lvl_sum   = lvl_q + LVL_W'(cnt);
  assign step_sum  = {1'b0, step_q} + STEP_ADD;
  assign step_up   = (step_sum > STEP_CAP) ? 5'(STEP_MAX) : step_sum[4:0];

  logic reinit;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    step_d  = step_q;
    lvl_d   = lvl_q;
    reinit  = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        // A collision freezes the field on the same clk, even if a tick arrives.
        if (|hit_w) begin
          state_d = S_OVER;
        end else if (tick_i) begin
          for (int i = 0; i < N_OBS; i++) begin
            if (resp_w[i]) begin
              x_d[i] = XS_C;
              y_d[i] = y_spawn[i];
            end else begin
              x_d[i] = x_mv[i];
            end
          end
          score_d = score_sat;
          if (lvl_sum >= LVL_PTS) begin
            lvl_d  = lvl_sum - LVL_PTS;
            step_d = step_up;
          end else begin
            lvl_d = lvl_sum;
          end
        end
      end
      S_OVER: if (start_i) begin
        reinit  = 1'b1;
        state_d = S_IDLE;
        score_d = '0;
        step_d  = STEP_RST;
        lvl_d   = '0;
        for (int i = 0; i < N_OBS; i++) begin
          x_d[i] = x_init(i);
          y_d[i] = YB_C;
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int i = 0; i < N_OBS; i++) lfsr_d[i] = reinit ? lfsr_init(i) : lfsr_nx[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      score_q <= '0;
      step_q  <= STEP_RST;
      lvl_q   <= '0;
      for (int i = 0; i < N_OBS; i++) begin
        x_q[i]    <= x_init(i);
        y_q[i]    <= YB_C;
        lfsr_q[i] <= lfsr_init(i);
      end
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      step_q  <= step_d;
      lvl_q   <= lvl_d;
      for (int i = 0; i < N_OBS; i++) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        lfsr_q[i] <= lfsr_d[i];
      end
    end
  end

  assign score_o     = score_q;
  assign step_o      = step_q;
  assign running_o   = (state_q == S_RUN);
  assign game_over_o = (state_q == S_OVER);
  assign state_o     = state_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: checkpoint table over a long scroll run, then
// hand-written collision, game-over, restart and asynchronous reset sequences.
module tb_obstacle_field;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  plane_y = 10'd20;
  logic [39:0] obs_x, obs_y;
  logic [7:0]  score;
  logic [4:0]  step;
  logic        game_over, running;
  logic [1:0]  state;

  obstacle_field dut (
    .clk         (clk),
    .resetn      (resetn),
    .tick_i      (tick),
    .start_i     (start),
    .plane_y_i   (plane_y),
    .obs_x_o     (obs_x),
    .obs_y_o     (obs_y),
    .score_o     (score),
    .step_o      (step),
    .game_over_o (game_over),
    .running_o   (running),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  // Reference for channel 0's respawn height: 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 0x1B.
  logic [7:0] m_lfsr0;
  logic [7:0] last_lfsr0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr0 <= 8'h1B;
    else         m_lfsr0 <= {m_lfsr0[6:0], m_lfsr0[7] ^ m_lfsr0[5] ^ m_lfsr0[4] ^ m_lfsr0[3]};
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          n_ticks;
    int          exp_score;
    int          exp_step;
    bit          chk_x;
    logic [39:0] exp_x;
  } vec_t;

  vec_t tbl [9];

  function automatic int chan(input logic [39:0] v, input int i);
    return int'(v[i*10 +: 10]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_x%0d", tag, i), chan(obs_x, i), 120 + (i + 1) * 120);
      chk($sformatf("%s_y%0d", tag, i), chan(obs_y, i), 100);
    end
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_step"}, int'(step), 8);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask

  task automatic do_tick();
    @(negedge clk);
    last_lfsr0 = m_lfsr0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Cumulative ticks: 1, 16, 121, 122, 220, 302, 372, 411, 434.
    tbl[0] = '{1,   0,  8,  1'b1, {10'd592, 10'd472, 10'd352, 10'd232}};
    tbl[1] = '{15,  1,  8,  1'b1, {10'd472, 10'd352, 10'd232, 10'd600}};
    tbl[2] = '{105, 7,  8,  1'b0, 40'd0};
    tbl[3] = '{1,   8,  10, 1'b1, {10'd600, 10'd480, 10'd360, 10'd240}};
    tbl[4] = '{98,  16, 12, 1'b1, {10'd600, 10'd480, 10'd360, 10'd240}};
    tbl[5] = '{82,  24, 14, 1'b1, {10'd600, 10'd480, 10'd360, 10'd240}};
    tbl[6] = '{70,  32, 16, 1'b1, {10'd600, 10'd474, 10'd362, 10'd236}};
    tbl[7] = '{39,  37, 16, 1'b0, 40'd0};
    tbl[8] = '{23,  40, 16, 1'b1, {10'd600, 10'd472, 10'd360, 10'd232}};

    idle_clks(2);
    resetn = 1'b1;
    idle_clks(1);
    check_reset_vals("reset");

    do_tick();
    chk("idle_tick_x0", chan(obs_x, 0), 240);
    chk("idle_tick_running", int'(running), 0);

    pulse_start();
    chk("start_running", int'(running), 1);
    chk("start_state", int'(state), 1);
    pulse_start();
    chk("start_in_run_x0", chan(obs_x, 0), 240);
    chk("start_in_run_running", int'(running), 1);

    for (int e = 0; e < 9; e++) begin
      repeat (tbl[e].n_ticks) do_tick();
      chk($sformatf("vec%0d_score", e), int'(score), tbl[e].exp_score);
      chk($sformatf("vec%0d_step", e), int'(step), tbl[e].exp_step);
      chk($sformatf("vec%0d_running", e), int'(running), 1);
      if (tbl[e].chk_x) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("vec%0d_x%0d", e, i), chan(obs_x, i), chan(tbl[e].exp_x, i));
      end
      if (e == 1) chk("respawn_y0", chan(obs_y, 0), 100 + int'(last_lfsr0[5:0]));
    end

    // Reset asserted mid-cycle must take effect before the next rising edge.
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    resetn = 1'b1;
    idle_clks(1);

    pulse_start();
    repeat (6) do_tick();
    plane_y = 10'd100;
    idle_clks(2);
    chk("x192_no_hit_running", int'(running), 1);
    chk("x192_x0", chan(obs_x, 0), 192);

    plane_y = 10'd20;
    do_tick();
    plane_y = 10'd124;
    idle_clks(2);
    chk("dy24_above_running", int'(running), 1);
    plane_y = 10'd76;
    idle_clks(2);
    chk("dy24_below_running", int'(running), 1);

    // Hit and tick in the same clk: hit wins, nothing moves.
    @(negedge clk);
    plane_y = 10'd77;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("hit_game_over", int'(game_over), 1);
    chk("hit_running", int'(running), 0);
    chk("hit_state", int'(state), 2);
    chk("hit_score", int'(score), 0);
    chk("hit_x0", chan(obs_x, 0), 184);
    chk("hit_x1", chan(obs_x, 1), 304);
    chk("hit_x2", chan(obs_x, 2), 424);
    chk("hit_x3", chan(obs_x, 3), 544);

    repeat (3) do_tick();
    chk("over_tick_x0", chan(obs_x, 0), 184);
    chk("over_tick_x3", chan(obs_x, 3), 544);
    chk("over_tick_step", int'(step), 8);
    chk("over_tick_game_over", int'(game_over), 1);

    plane_y = 10'd20;
    pulse_start();
    check_reset_vals("restart");
    do_tick();
    chk("restart_idle_tick_x0", chan(obs_x, 0), 240);
    pulse_start();
    chk("rerun_running", int'(running), 1);
    do_tick();
    chk("rerun_tick_x0", chan(obs_x, 0), 232);
    chk("rerun_tick_x3", chan(obs_x, 3), 592);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
